// File: rtl/ps2_digit_entry_pkg.sv
// Shared constants for the PS/2 keypad digit-entry block: set-2 scancodes,
// decoderBCD display codes, decoder states and decoded key actions.
package ps2_digit_entry_pkg;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_MAIN_0 = 8'h45;
  localparam logic [7:0] SC_MAIN_1 = 8'h16;
  localparam logic [7:0] SC_MAIN_2 = 8'h1E;
  localparam logic [7:0] SC_MAIN_3 = 8'h26;
  localparam logic [7:0] SC_MAIN_4 = 8'h25;
  localparam logic [7:0] SC_MAIN_5 = 8'h2E;
  localparam logic [7:0] SC_MAIN_6 = 8'h36;
  localparam logic [7:0] SC_MAIN_7 = 8'h3D;
  localparam logic [7:0] SC_MAIN_8 = 8'h3E;
  localparam logic [7:0] SC_MAIN_9 = 8'h46;

  localparam logic [7:0] SC_KP_0 = 8'h70;
  localparam logic [7:0] SC_KP_1 = 8'h69;
  localparam logic [7:0] SC_KP_2 = 8'h72;
  localparam logic [7:0] SC_KP_3 = 8'h7A;
  localparam logic [7:0] SC_KP_4 = 8'h6B;
  localparam logic [7:0] SC_KP_5 = 8'h73;
  localparam logic [7:0] SC_KP_6 = 8'h74;
  localparam logic [7:0] SC_KP_7 = 8'h6C;
  localparam logic [7:0] SC_KP_8 = 8'h75;
  localparam logic [7:0] SC_KP_9 = 8'h7D;

  localparam logic [13:0] CODE_EMPTY = 14'd10001;
  localparam logic [13:0] CODE_ERROR = 14'd10002;

  typedef enum logic [1:0] {
    S_MAKE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_DIGIT,
    ACT_BKSP,
    ACT_ESC,
    ACT_ENTER
  } action_t;

  // Shift-and-add form of acc*10 + d; at most 4 digits, so 14 bits never overflow.
  function automatic logic [13:0] times_ten_plus(input logic [13:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + {10'd0, d};
  endfunction

endpackage

// File: rtl/ps2_digit_entry_if.sv
// Byte-in / value-out bundle between the PS/2 receiver, the digit-entry block
// and decoderBCD.
interface ps2_digit_entry_if;

  logic [7:0]  scan_code;
  logic        scan_valid;
  logic [13:0] display_value;
  logic [2:0]  digit_count;
  logic [13:0] commit_value;
  logic        commit_valid;
  logic        error;

  modport master (
    output scan_code,
    output scan_valid,
    input  display_value,
    input  digit_count,
    input  commit_value,
    input  commit_valid,
    input  error
  );

  modport slave (
    input  scan_code,
    input  scan_valid,
    output display_value,
    output digit_count,
    output commit_value,
    output commit_valid,
    output error
  );

endinterface

// File: rtl/ps2_digit_entry_scan_to_digit.sv
// Combinational scancode-to-digit lookup covering both the main number row and
// the numeric keypad.
module ps2_scan_to_digit
  import ps2_digit_entry_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_digit,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (code)
      SC_MAIN_0, SC_KP_0: digit = 4'd0;
      SC_MAIN_1, SC_KP_1: digit = 4'd1;
      SC_MAIN_2, SC_KP_2: digit = 4'd2;
      SC_MAIN_3, SC_KP_3: digit = 4'd3;
      SC_MAIN_4, SC_KP_4: digit = 4'd4;
      SC_MAIN_5, SC_KP_5: digit = 4'd5;
      SC_MAIN_6, SC_KP_6: digit = 4'd6;
      SC_MAIN_7, SC_KP_7: digit = 4'd7;
      SC_MAIN_8, SC_KP_8: digit = 4'd8;
      SC_MAIN_9, SC_KP_9: digit = 4'd9;
      default:            is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_digit_entry.sv
// PS/2 set-2 keypad number entry: decodes make/break/extended byte sequences and
// builds a up-to-MAX_DIGITS decimal value for decoderBCD, committed with ENTER.
module ps2_digit_entry #(
  parameter int          MAX_DIGITS = 4,
  parameter logic [13:0] CODE_EMPTY = ps2_digit_entry_pkg::CODE_EMPTY,
  parameter logic [13:0] CODE_ERROR = ps2_digit_entry_pkg::CODE_ERROR
) (
  input logic               clock,
  input logic               reset_n,
  ps2_digit_entry_if.slave  bus
);

  import ps2_digit_entry_pkg::*;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t      state, state_nxt;
  action_t     action;
  logic [7:0]  last_make, last_make_nxt;
  logic [13:0] acc, acc_nxt;
  logic [2:0]  count, count_nxt;
  logic        error, error_nxt;
  logic [13:0] commit_value, commit_value_nxt;
  logic        commit_valid, commit_valid_nxt;
  logic        is_digit;
  logic [3:0]  digit;

  ps2_scan_to_digit u_scan_to_digit (
    .code     (bus.scan_code),
    .is_digit (is_digit),
    .digit    (digit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_MAKE;
      last_make    <= 8'h00;
      acc          <= 14'd0;
      count        <= 3'd0;
      error        <= 1'b0;
      commit_value <= 14'd0;
      commit_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_make    <= last_make_nxt;
      acc          <= acc_nxt;
      count        <= count_nxt;
      error        <= error_nxt;
      commit_value <= commit_value_nxt;
      commit_valid <= commit_valid_nxt;
    end
  end

  // Sequence decoder: turns the raw byte stream into at most one key action per byte.
  always_comb begin
    state_nxt     = state;
    last_make_nxt = last_make;
    action        = ACT_NONE;
    if (bus.scan_valid) begin
      case (state)
        S_MAKE: begin
          if (bus.scan_code == SC_BRK) begin
            state_nxt = S_BRK;
          end else if (bus.scan_code == SC_EXT) begin
            state_nxt = S_EXT;
          end else if (bus.scan_code != last_make) begin
            last_make_nxt = bus.scan_code;
            if (is_digit) begin
              action = ACT_DIGIT;
            end else begin
              case (bus.scan_code)
                SC_ENTER: action = ACT_ENTER;
                SC_BKSP:  action = ACT_BKSP;
                SC_ESC:   action = ACT_ESC;
                default:  action = ACT_NONE;
              endcase
            end
          end
        end
        S_BRK: begin
          if (bus.scan_code == last_make) begin
            last_make_nxt = 8'h00;
          end
          state_nxt = S_MAKE;
        end
        S_EXT: begin
          if (bus.scan_code == SC_BRK) begin
            state_nxt = S_EXT_BRK;
          end else begin
            state_nxt = S_MAKE;
            if (bus.scan_code == SC_ENTER) begin
              action = ACT_ENTER;
            end
          end
        end
        default: state_nxt = S_MAKE;
      endcase
    end
  end

  // Entry datapath. A BACKSPACE in the error state only clears the error: the
  // rejected overflow digit was never added, so the entered digits stay intact.
  always_comb begin
    acc_nxt          = acc;
    count_nxt        = count;
    error_nxt        = error;
    commit_value_nxt = commit_value;
    commit_valid_nxt = 1'b0;
    case (action)
      ACT_DIGIT: begin
        if (!error) begin
          if (count < MAX_CNT) begin
            acc_nxt   = times_ten_plus(acc, digit);
            count_nxt = count + 3'd1;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      ACT_BKSP: begin
        if (error) begin
          error_nxt = 1'b0;
        end else if (count != 3'd0) begin
          acc_nxt   = acc / 14'd10;
          count_nxt = count - 3'd1;
        end
      end
      ACT_ESC: begin
        acc_nxt   = 14'd0;
        count_nxt = 3'd0;
        error_nxt = 1'b0;
      end
      ACT_ENTER: begin
        if (count != 3'd0 && !error) begin
          commit_value_nxt = acc;
          commit_valid_nxt = 1'b1;
          acc_nxt          = 14'd0;
          count_nxt        = 3'd0;
        end
      end
      default: ;
    endcase
  end

  assign bus.display_value = error ? CODE_ERROR : ((count == 3'd0) ? CODE_EMPTY : acc);
  assign bus.digit_count   = count;
  assign bus.commit_value  = commit_value;
  assign bus.commit_valid  = commit_valid;
  assign bus.error         = error;

endmodule
